fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter AW, default 7: instruction address width, 128-word instruction store.
REQ-002 Parameter DW, default 32: instruction word width.
REQ-003 Parameter RESET_PC, default 7'h00: program counter value at reset.
REQ-004 Port Clock, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port Reset, input, 1: asynchronous, active-low reset.
REQ-006 Port Enable, input, 1: high permits new fetches; low parks the sequencer in IDLE.
REQ-007 Port MemRd, output, 1: read strobe to the instruction store, one cycle per fetch.
REQ-008 Port MemAdx, output, AW: word address to the instruction store; valid while MemRd=1.
REQ-009 Port MemData, input, DW: store read data, valid in the cycle after MemRd=1.
REQ-010 Port Instruction, output, DW: registered instruction word presented to the decoder.
REQ-011 Port InstPC, output, AW: address from which Instruction was fetched.
REQ-012 Port InstValid, output, 1: Instruction and InstPC are valid.
REQ-013 Port DecodeReady, input, 1: decoder accepts Instruction in any cycle where InstValid=1 and DecodeReady=1.
REQ-014 Port BranchTaken, input, 1: single-cycle redirect request.
REQ-015 Port BranchTarget, input, AW: redirect address, sampled when BranchTaken=1.
REQ-016 Port Halt, input, 1: stop fetching permanently until reset.
REQ-017 Port Halted, output, 1: the sequencer is in HALTED.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT, HOLD, and HALTED, encoded in one state register.
REQ-019 IDLE: MemRd=0 and InstValid=0; if Enable=1, the next state SHALL be REQ.
REQ-020 REQ: MemRd=1 and MemAdx=PC (both combinational from state and PC); the next state SHALL be WAIT.
REQ-021 WAIT: at the clock edge, the sequencer SHALL load Instruction with MemData, load InstPC with PC, set PC to PC+1 modulo 2^AW (7'h7F wraps to 7'h00), set InstValid=1, and go to HOLD.
REQ-022 HOLD: InstValid=1; Instruction and InstPC SHALL be held stable until acceptance.
REQ-023 In HOLD, if DecodeReady=1, InstValid SHALL drop next cycle; next state is REQ if Enable=1, otherwise IDLE.
REQ-024 Throughput with DecodeReady held high SHALL be one instruction per 3 cycles; fetch-to-InstValid latency SHALL be 2 cycles from entering REQ.
REQ-025 BranchTaken=1 in IDLE, REQ, WAIT, or HOLD SHALL load PC with BranchTarget and set the next state to REQ (IDLE if Enable=0).
REQ-026 A branch during REQ or WAIT SHALL discard the in-flight word; Instruction, InstPC, and InstValid are not updated from it.
REQ-027 A branch during HOLD SHALL clear InstValid next cycle even if DecodeReady=1; the held instruction counts as accepted only if DecodeReady=1 in that cycle.
REQ-028 Halt=1 in any state SHALL force HALTED next cycle, clear InstValid, and leave PC unchanged.
REQ-029 Priority SHALL be Halt > BranchTaken > DecodeReady/Enable.
REQ-030 HALTED: MemRd=0, InstValid=0, Halted=1, all inputs ignored; exit only via Reset.
REQ-031 At most one MemRd pulse SHALL be outstanding; MemRd is never asserted in consecutive cycles.

Reset
REQ-032 Reset low SHALL immediately, without a clock, set state=IDLE, PC=RESET_PC, Instruction=0, InstPC=0, InstValid=0, and Halted=0.
REQ-033 MemRd SHALL be 0 while Reset is low.
REQ-034 Reset asserted mid-fetch SHALL abandon the fetch; the first fetch after release SHALL be from RESET_PC.
REQ-035 Reset deassertion SHALL be synchronised by the integrating design; this block assumes Reset is released away from the rising edge of Clock.

Verification
REQ-036 Reset release, Enable=1, DecodeReady=1, store preloaded IM[k]=k -> MemAdx sequence 0,1,2 on MemRd pulses 3 cycles apart; Instruction=0,1,2 with InstPC matching.
REQ-037 DecodeReady=0 for 5 cycles in HOLD -> Instruction and InstPC stable, InstValid=1, no MemRd; DecodeReady=1 -> next MemAdx = InstPC+1.
REQ-038 BranchTaken=1 with BranchTarget=7'h40 during WAIT -> no InstValid for the discarded word; next MemAdx=7'h40, then InstPC=7'h40.
REQ-039 PC=7'h7F fetched -> InstPC=7'h7F, next MemAdx=7'h00.
REQ-040 Halt and BranchTaken asserted together in HOLD -> Halted=1 next cycle, InstValid=0, no further MemRd for 20 cycles; Reset pulse -> IDLE, PC=RESET_PC.
REQ-041 Reset low during WAIT -> outputs clear without a clock edge; after release, the first MemAdx is 7'h00.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one store read per instruction, holds the
// fetched word for the decoder, and handles branch redirects and a sticky halt.
module fetch_sequencer #(
  parameter int              AW       = 7,
  parameter int              DW       = 32,
  parameter logic [AW-1:0]   RESET_PC = 7'h00
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Enable,
  output logic          MemRd,
  output logic [AW-1:0] MemAdx,
  input  logic [DW-1:0] MemData,
  output logic [DW-1:0] Instruction,
  output logic [AW-1:0] InstPC,
  output logic          InstValid,
  input  logic          DecodeReady,
  input  logic          BranchTaken,
  input  logic [AW-1:0] BranchTarget,
  input  logic          Halt,
  output logic          Halted
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    HOLD   = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t        state, nextState;
  logic [AW-1:0] pc;
  logic [DW-1:0] instReg;
  logic [AW-1:0] instPcReg;
  logic          instValidReg;
  logic          loadFetch;
  logic          loadBranch;

  // Halt beats a branch, which beats normal sequencing; HALTED only leaves via reset.
  always_comb begin
    nextState  = state;
    loadFetch  = 1'b0;
    loadBranch = 1'b0;
    if (state == HALTED) begin
      nextState = HALTED;
    end else if (Halt) begin
      nextState = HALTED;
    end else if (BranchTaken) begin
      loadBranch = 1'b1;
      nextState  = Enable ? REQ : IDLE;
    end else begin
      case (state)
        IDLE:    nextState = Enable ? REQ : IDLE;
        REQ:     nextState = WAIT;
        WAIT: begin
          loadFetch = 1'b1;
          nextState = HOLD;
        end
        HOLD: begin
          if (DecodeReady) nextState = Enable ? REQ : IDLE;
        end
        default: nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      instReg      <= '0;
      instPcReg    <= '0;
      instValidReg <= 1'b0;
    end else begin
      state        <= nextState;
      instValidReg <= (nextState == HOLD);
      if (loadBranch) begin
        pc <= BranchTarget;
      end else if (loadFetch) begin
        instReg   <= MemData;
        instPcReg <= pc;
        pc        <= pc + AW'(1);
      end
    end
  end

  assign MemRd       = (state == REQ);
  assign MemAdx      = pc;
  assign Instruction = instReg;
  assign InstPC      = instPcReg;
  assign InstValid   = instValidReg;
  assign Halted      = (state == HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand-written corner sequences,
// then random traffic compared against a transaction-level model.
module tb_fetch_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Enable = 1'b0;
  logic        MemRd;
  logic [6:0]  MemAdx;
  logic [31:0] MemData = '0;
  logic [31:0] Instruction;
  logic [6:0]  InstPC;
  logic        InstValid;
  logic        DecodeReady = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [6:0]  BranchTarget = '0;
  logic        Halt = 1'b0;
  logic        Halted;

  int errors = 0;
  int checks = 0;
  logic [31:0] mem [128];

  fetch_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .MemRd(MemRd), .MemAdx(MemAdx),
    .MemData(MemData), .Instruction(Instruction), .InstPC(InstPC), .InstValid(InstValid),
    .DecodeReady(DecodeReady), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Halt(Halt), .Halted(Halted)
  );

  always #5 Clock = ~Clock;

  // Instruction store: data appears the cycle after the read strobe, junk otherwise.
  always @(posedge Clock) MemData <= MemRd ? mem[MemAdx] : 32'hDEAD_BEEF;

  typedef struct packed {
    logic        en, dr, br;
    logic [6:0]  tgt;
    logic        halt;
    logic        expRd;
    logic [6:0]  expAdx;
    logic        expValid;
    logic [31:0] expInst;
    logic [6:0]  expPc;
    logic        expHalted;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic en, dr, br, input logic [6:0] tgt, input logic halt,
                              input logic rd, input logic [6:0] adx, input logic v,
                              input logic [31:0] inst, input logic [6:0] pcv, input logic h);
    vec_t r;
    r.en = en; r.dr = dr; r.br = br; r.tgt = tgt; r.halt = halt;
    r.expRd = rd; r.expAdx = adx; r.expValid = v; r.expInst = inst; r.expPc = pcv; r.expHalted = h;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, dr, br, input logic [6:0] tgt, input logic halt);
    Enable = en; DecodeReady = dr; BranchTaken = br; BranchTarget = tgt; Halt = halt;
  endtask

  // Waits (bounded) for the next read strobe and checks its address.
  task automatic waitForFetch(input string name, input logic [6:0] expAdx);
    int n = 0;
    while (MemRd !== 1'b1 && n < 10) begin
      @(negedge Clock);
      n++;
    end
    checkOutput({name, "_seen"}, 32'(MemRd), 32'd1);
    if (MemRd === 1'b1) checkOutput({name, "_adx"}, 32'(MemAdx), 32'(expAdx));
  endtask

  // Transaction-level reference: one in-flight request, one held word.
  bit          mIssue, mArrive, mHeld, mHalted;
  logic [6:0]  mPc, mHPc;
  logic [31:0] mHInst;

  task automatic modelStep(input logic en, dr, br, input logic [6:0] tgt, input logic halt);
    if (mHalted) return;
    if (halt) begin
      mHalted = 1; mHeld = 0; mIssue = 0; mArrive = 0;
    end else if (br) begin
      mPc = tgt; mHeld = 0; mArrive = 0; mIssue = en;
    end else if (mArrive) begin
      mHeld = 1; mHInst = mem[mPc]; mHPc = mPc; mPc = 7'((int'(mPc) + 1) % 128); mArrive = 0;
    end else if (mIssue) begin
      mIssue = 0; mArrive = 1;
    end else if (mHeld) begin
      if (dr) begin mHeld = 0; mIssue = en; end
    end else begin
      mIssue = en;
    end
  endtask

  initial begin
    for (int k = 0; k < 128; k++) mem[k] = 32'(k);

    vecs[0]  = mk(1,1,0,7'h00,0, 0,7'h00,0,32'h0, 7'h00,0);
    vecs[1]  = mk(1,1,0,7'h00,0, 1,7'h00,0,32'h0, 7'h00,0);
    vecs[2]  = mk(1,1,0,7'h00,0, 0,7'h00,0,32'h0, 7'h00,0);
    vecs[3]  = mk(1,1,0,7'h00,0, 0,7'h00,1,32'h0, 7'h00,0);
    vecs[4]  = mk(1,1,0,7'h00,0, 1,7'h01,0,32'h0, 7'h00,0);
    vecs[5]  = mk(1,1,0,7'h00,0, 0,7'h00,0,32'h0, 7'h00,0);
    vecs[6]  = mk(1,0,0,7'h00,0, 0,7'h00,1,32'h1, 7'h01,0);
    vecs[7]  = mk(1,0,0,7'h00,0, 0,7'h00,1,32'h1, 7'h01,0);
    vecs[8]  = mk(1,0,0,7'h00,0, 0,7'h00,1,32'h1, 7'h01,0);
    vecs[9]  = mk(1,0,0,7'h00,0, 0,7'h00,1,32'h1, 7'h01,0);
    vecs[10] = mk(1,0,0,7'h00,0, 0,7'h00,1,32'h1, 7'h01,0);
    vecs[11] = mk(1,1,0,7'h00,0, 0,7'h00,1,32'h1, 7'h01,0);
    vecs[12] = mk(1,1,0,7'h00,0, 1,7'h02,0,32'h1, 7'h01,0);
    vecs[13] = mk(1,1,1,7'h40,0, 0,7'h00,0,32'h1, 7'h01,0);
    vecs[14] = mk(1,1,0,7'h00,0, 1,7'h40,0,32'h1, 7'h01,0);
    vecs[15] = mk(1,1,0,7'h00,0, 0,7'h00,0,32'h1, 7'h01,0);
    vecs[16] = mk(1,1,1,7'h10,1, 0,7'h00,1,32'h40,7'h40,0);
    vecs[17] = mk(1,1,0,7'h00,0, 0,7'h00,0,32'h40,7'h40,1);

    #12;
    checkOutput("rst_rd", 32'(MemRd), 32'd0);
    checkOutput("rst_valid", 32'(InstValid), 32'd0);
    checkOutput("rst_halted", 32'(Halted), 32'd0);
    checkOutput("rst_inst", Instruction, 32'd0);
    checkOutput("rst_instpc", 32'(InstPC), 32'd0);
    checkOutput("rst_adx", 32'(MemAdx), 32'd0);
    @(negedge Clock);
    Reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge Clock);
      checkOutput($sformatf("vec%0d_rd", i), 32'(MemRd), 32'(vecs[i].expRd));
      if (vecs[i].expRd) checkOutput($sformatf("vec%0d_adx", i), 32'(MemAdx), 32'(vecs[i].expAdx));
      checkOutput($sformatf("vec%0d_valid", i), 32'(InstValid), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d_inst", i), Instruction, vecs[i].expInst);
      checkOutput($sformatf("vec%0d_instpc", i), 32'(InstPC), 32'(vecs[i].expPc));
      checkOutput($sformatf("vec%0d_halted", i), 32'(Halted), 32'(vecs[i].expHalted));
      applyStimulus(vecs[i].en, vecs[i].dr, vecs[i].br, vecs[i].tgt, vecs[i].halt);
    end

    for (int c = 0; c < 20; c++) begin
      @(negedge Clock);
      checkOutput("halt_rd", 32'(MemRd), 32'd0);
      checkOutput("halt_halted", 32'(Halted), 32'd1);
      checkOutput("halt_valid", 32'(InstValid), 32'd0);
      applyStimulus(1'b1, 1'($urandom), 1'($urandom), 7'($urandom), 1'b0);
    end

    @(negedge Clock);
    applyStimulus(1, 1, 0, 7'h00, 0);
    Reset = 1'b0;
    #1;
    checkOutput("haltrst_halted", 32'(Halted), 32'd0);
    checkOutput("haltrst_adx", 32'(MemAdx), 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    waitForFetch("post_halt", 7'h00);

    applyStimulus(1, 1, 1, 7'h7F, 0);
    @(negedge Clock);
    applyStimulus(1, 1, 0, 7'h00, 0);
    checkOutput("wrap_rd", 32'(MemRd), 32'd1);
    checkOutput("wrap_adx", 32'(MemAdx), 32'h7F);
    @(negedge Clock);
    @(negedge Clock);
    checkOutput("wrap_valid", 32'(InstValid), 32'd1);
    checkOutput("wrap_instpc", 32'(InstPC), 32'h7F);
    checkOutput("wrap_inst", Instruction, 32'h7F);
    @(negedge Clock);
    checkOutput("wrap_next_rd", 32'(MemRd), 32'd1);
    checkOutput("wrap_next_adx", 32'(MemAdx), 32'h00);

    @(negedge Clock);
    Reset = 1'b0;
    #1;
    checkOutput("midrst_rd", 32'(MemRd), 32'd0);
    checkOutput("midrst_valid", 32'(InstValid), 32'd0);
    checkOutput("midrst_inst", Instruction, 32'd0);
    checkOutput("midrst_instpc", 32'(InstPC), 32'd0);
    checkOutput("midrst_halted", 32'(Halted), 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    waitForFetch("midrst_first", 7'h00);

    @(negedge Clock);
    Reset = 1'b0;
    applyStimulus(0, 0, 0, 7'h00, 0);
    for (int k = 0; k < 128; k++) mem[k] = $urandom;
    mIssue = 0; mArrive = 0; mHeld = 0; mHalted = 0;
    mPc = 7'h00; mHPc = 7'h00; mHInst = '0;
    @(negedge Clock);
    Reset = 1'b1;

    for (int c = 0; c < 400; c++) begin
      logic en, dr, br, halt;
      logic [6:0] tgt;
      @(negedge Clock);
      checkOutput("rnd_rd", 32'(MemRd), 32'(mIssue));
      if (mIssue) checkOutput("rnd_adx", 32'(MemAdx), 32'(mPc));
      checkOutput("rnd_valid", 32'(InstValid), 32'(mHeld));
      checkOutput("rnd_inst", Instruction, mHInst);
      checkOutput("rnd_instpc", 32'(InstPC), 32'(mHPc));
      checkOutput("rnd_halted", 32'(Halted), 32'(mHalted));
      en   = ($urandom_range(7) != 0);
      dr   = ($urandom_range(2) != 0);
      br   = ($urandom_range(9) == 0);
      tgt  = 7'($urandom);
      halt = (c == 380);
      applyStimulus(en, dr, br, tgt, halt);
      modelStep(en, dr, br, tgt, halt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
